// File: rtl/p_shfrot_arb.sv
// Two-port arbiter sharing one packed shift/rotate datapath, with a single tagged response buffer.
// Optional request checking is enabled by defining P_SHFROT_ARB_CHECK_EN.
module p_shfrot_arb #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_crs1,
  input  logic [4:0]  req0_shamt,
  input  logic [4:0]  req0_pw,
  input  logic        req0_shift,
  input  logic        req0_rotate,
  input  logic        req0_left,
  input  logic        req0_right,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic        rsp0_error,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_crs1,
  input  logic [4:0]  req1_shamt,
  input  logic [4:0]  req1_pw,
  input  logic        req1_shift,
  input  logic        req1_rotate,
  input  logic        req1_left,
  input  logic        req1_right,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic        rsp1_error
);

  typedef enum logic {EMPTY, FULL} bufState_e;

  bufState_e   state_q, state_d;
  logic        owner_q, owner_d;
  logic        lastGrant_q, lastGrant_d;
  logic [31:0] result_q, result_d;

  logic        grant0, grant1, canAccept, drain, accept;
  logic [31:0] selCrs1, shfResult, newResult;
  logic [4:0]  selShamt, selPw;
  logic        selShift, selRotate, selLeft, selRight;

  // Shift or rotate every lane of width w independently; the shift amount wraps within a lane.
  function automatic logic [31:0] laneShfrot(input logic [31:0] crs1, input logic [4:0] shamt,
                                             input logic rotate, input logic left, input int w);
    logic [31:0] r;
    int s, base, j;
    r = '0;
    s = int'(shamt) & (w - 1);
    for (int i = 0; i < 32; i++) begin
      base = i & ~(w - 1);
      j    = i - base;
      if (left) begin
        if (j >= s)      r[i] = crs1[5'(base + j - s)];
        else if (rotate) r[i] = crs1[5'(base + j - s + w)];
      end else begin
        if (j + s < w)   r[i] = crs1[5'(base + j + s)];
        else if (rotate) r[i] = crs1[5'(base + j + s - w)];
      end
    end
    return r;
  endfunction

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0 = RR_EN ? lastGrant_q : 1'b1;
      grant1 = ~grant0;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  assign drain      = (state_q == FULL) && (owner_q ? rsp1_ready : rsp0_ready);
  assign canAccept  = (state_q == EMPTY) || drain;
  assign req0_ready = g_resetn & canAccept & grant0;
  assign req1_ready = g_resetn & canAccept & grant1;
  assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  always_comb begin
    selCrs1   = grant1 ? req1_crs1   : req0_crs1;
    selShamt  = grant1 ? req1_shamt  : req0_shamt;
    selPw     = grant1 ? req1_pw     : req0_pw;
    selShift  = grant1 ? req1_shift  : req0_shift;
    selRotate = grant1 ? req1_rotate : req0_rotate;
    selLeft   = grant1 ? req1_left   : req0_left;
    selRight  = grant1 ? req1_right  : req0_right;
  end

  // pw[0] selects full 32-bit lanes, pw[4] selects 2-bit lanes; the lowest set bit wins.
  always_comb begin
    logic doRotate, doLeft;
    doRotate = selRotate & ~selShift;
    doLeft   = selLeft & ~selRight;
    if (selPw[0])      shfResult = laneShfrot(selCrs1, selShamt, doRotate, doLeft, 32);
    else if (selPw[1]) shfResult = laneShfrot(selCrs1, selShamt, doRotate, doLeft, 16);
    else if (selPw[2]) shfResult = laneShfrot(selCrs1, selShamt, doRotate, doLeft, 8);
    else if (selPw[3]) shfResult = laneShfrot(selCrs1, selShamt, doRotate, doLeft, 4);
    else               shfResult = laneShfrot(selCrs1, selShamt, doRotate, doLeft, 2);
  end

`ifdef P_SHFROT_ARB_CHECK_EN
  logic error_q, error_d, malformed;

  assign malformed = !$onehot(selPw) || !(selShift ^ selRotate) || !(selLeft ^ selRight);
  assign newResult = malformed ? 32'h0 : shfResult;

  always_comb begin
    error_d = error_q;
    if (accept) error_d = malformed;
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) error_q <= 1'b0;
    else           error_q <= error_d;
  end

  assign rsp0_error = rsp0_valid & error_q;
  assign rsp1_error = rsp1_valid & error_q;
`else
  assign newResult  = shfResult;
  assign rsp0_error = 1'b0;
  assign rsp1_error = 1'b0;
`endif

  // Accept wins over drain so a same-cycle drain and accept leaves no bubble.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lastGrant_d = lastGrant_q;
    result_d    = result_q;
    if (accept) begin
      state_d     = FULL;
      owner_d     = grant1;
      lastGrant_d = grant1;
      result_d    = newResult;
    end else if (drain) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q     <= EMPTY;
      owner_q     <= 1'b0;
      lastGrant_q <= 1'b1;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lastGrant_q <= lastGrant_d;
      result_q    <= result_d;
    end
  end

  assign rsp0_valid  = (state_q == FULL) && !owner_q;
  assign rsp1_valid  = (state_q == FULL) &&  owner_q;
  assign rsp0_result = rsp0_valid ? result_q : 32'h0;
  assign rsp1_result = rsp1_valid ? result_q : 32'h0;

endmodule

// File: tb/tb_p_shfrot_arb.sv
// Scoreboard bench for p_shfrot_arb: expected responses are queued per port on accept
// and compared when the owning port consumes its response.
module tb_p_shfrot_arb;

  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b0;
  logic        req0_valid, req0_ready, req0_shift, req0_rotate, req0_left, req0_right;
  logic [31:0] req0_crs1;
  logic [4:0]  req0_shamt, req0_pw;
  logic        rsp0_valid, rsp0_ready, rsp0_error;
  logic [31:0] rsp0_result;
  logic        req1_valid, req1_ready, req1_shift, req1_rotate, req1_left, req1_right;
  logic [31:0] req1_crs1;
  logic [4:0]  req1_shamt, req1_pw;
  logic        rsp1_valid, rsp1_ready, rsp1_error;
  logic [31:0] rsp1_result;

  int checkCount = 0;
  int errorCount = 0;
  logic [32:0] expQ0[$];
  logic [32:0] expQ1[$];

  p_shfrot_arb #(.RR_EN(1'b1)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_crs1(req0_crs1),
    .req0_shamt(req0_shamt), .req0_pw(req0_pw), .req0_shift(req0_shift),
    .req0_rotate(req0_rotate), .req0_left(req0_left), .req0_right(req0_right),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_error(rsp0_error),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_crs1(req1_crs1),
    .req1_shamt(req1_shamt), .req1_pw(req1_pw), .req1_shift(req1_shift),
    .req1_rotate(req1_rotate), .req1_left(req1_left), .req1_right(req1_right),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_error(rsp1_error)
  );

  always #5 g_clk = ~g_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference: extract each lane, shift it, and OR in the wrapped-out bits for rotates.
  function automatic logic [32:0] modelShfrot(input logic [31:0] crs1, input logic [4:0] shamt,
      input logic [4:0] pw, input logic shift, input logic rotate, input logic left, input logic right);
    longint unsigned c, w, s, mask, lane, sh, wrap, res;
    logic doRot, doLeft;
`ifdef P_SHFROT_ARB_CHECK_EN
    if ($countones(pw) != 1 || shift == rotate || left == right) return {1'b1, 32'h0};
`endif
    doRot  = rotate & ~shift;
    doLeft = left & ~right;
    w = pw[0] ? 32 : pw[1] ? 16 : pw[2] ? 8 : pw[3] ? 4 : 2;
    s = longint'(shamt) % w;
    mask = (64'd1 << w) - 1;
    c = longint'(crs1);
    res = 0;
    for (int k = 0; k < 32 / int'(w); k++) begin
      lane = (c >> (k * w)) & mask;
      if (doLeft) begin
        sh   = (lane << s) & mask;
        wrap = (s != 0) ? (lane >> (w - s)) : 0;
      end else begin
        sh   = lane >> s;
        wrap = (s != 0) ? ((lane << (w - s)) & mask) : 0;
      end
      if (!doRot) wrap = 0;
      res |= (sh | wrap) << (k * w);
    end
    return {1'b0, res[31:0]};
  endfunction

  // Scoreboard monitor: push on accept, pop and compare when the owner consumes.
  always @(negedge g_clk) begin
    if (g_resetn) begin
      logic [32:0] e;
      checkOutput("oneReady", 32'(req0_ready & req1_ready), 32'h0);
      if (rsp0_valid && rsp0_ready) begin
        if (expQ0.size() == 0) checkOutput("rsp0Unexpected", 32'h1, 32'h0);
        else begin
          e = expQ0.pop_front();
          checkOutput("rsp0Result", rsp0_result, e[31:0]);
          checkOutput("rsp0Error", 32'(rsp0_error), 32'(e[32]));
        end
      end
      if (rsp1_valid && rsp1_ready) begin
        if (expQ1.size() == 0) checkOutput("rsp1Unexpected", 32'h1, 32'h0);
        else begin
          e = expQ1.pop_front();
          checkOutput("rsp1Result", rsp1_result, e[31:0]);
          checkOutput("rsp1Error", 32'(rsp1_error), 32'(e[32]));
        end
      end
      if (!rsp0_valid) checkOutput("rsp0IdleZero", rsp0_result, 32'h0);
      if (!rsp1_valid) checkOutput("rsp1IdleZero", rsp1_result, 32'h0);
      if (req0_valid && req0_ready)
        expQ0.push_back(modelShfrot(req0_crs1, req0_shamt, req0_pw, req0_shift, req0_rotate, req0_left, req0_right));
      if (req1_valid && req1_ready)
        expQ1.push_back(modelShfrot(req1_crs1, req1_shamt, req1_pw, req1_shift, req1_rotate, req1_left, req1_right));
    end
  end

  task automatic applyStimulus(input int port, input logic [31:0] crs1, input logic [4:0] shamt,
      input logic [4:0] pw, input logic shift, input logic rotate, input logic left, input logic right);
    if (port == 0) begin
      req0_valid = 1'b1; req0_crs1 = crs1; req0_shamt = shamt; req0_pw = pw;
      req0_shift = shift; req0_rotate = rotate; req0_left = left; req0_right = right;
    end else begin
      req1_valid = 1'b1; req1_crs1 = crs1; req1_shamt = shamt; req1_pw = pw;
      req1_shift = shift; req1_rotate = rotate; req1_left = left; req1_right = right;
    end
  endtask

  // Waits (bounded) for the accept of a port, then drops its valid just after the accept edge.
  task automatic waitAccept(input int port);
    bit got = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge g_clk);
      if (port == 0 ? (req0_valid && req0_ready) : (req1_valid && req1_ready)) begin
        got = 1;
        break;
      end
    end
    if (!got) checkOutput($sformatf("acceptTimeout%0d", port), 32'h0, 32'h1);
    @(posedge g_clk);
    #1;
    if (port == 0) req0_valid = 1'b0;
    else           req1_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    req0_valid = 1'b1; req0_crs1 = '0; req0_shamt = '0; req0_pw = 5'b00001;
    req0_shift = 1'b1; req0_rotate = 1'b0; req0_left = 1'b1; req0_right = 1'b0;
    req1_valid = 1'b1; req1_crs1 = '0; req1_shamt = '0; req1_pw = 5'b00001;
    req1_shift = 1'b1; req1_rotate = 1'b0; req1_left = 1'b1; req1_right = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;

    #12;
    checkOutput("resetReady0", 32'(req0_ready), 32'h0);
    checkOutput("resetReady1", 32'(req1_ready), 32'h0);
    checkOutput("resetValid0", 32'(rsp0_valid), 32'h0);
    checkOutput("resetValid1", 32'(rsp1_valid), 32'h0);
    checkOutput("resetResult0", rsp0_result, 32'h0);
    checkOutput("resetError0", 32'(rsp0_error), 32'h0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge g_clk); #1;
    g_resetn = 1'b1;

    // Round-robin from reset with both ports requesting continuously.
    applyStimulus(0, 32'hA5A5_0F0F, 5'd3, 5'b00100, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1, 32'h1357_9BDF, 5'd7, 5'b00010, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge g_clk);
      checkOutput($sformatf("rrGrant0_%0d", i), 32'(req0_ready), 32'((i % 2) == 0));
      checkOutput($sformatf("rrGrant1_%0d", i), 32'(req1_ready), 32'((i % 2) == 1));
      if (i > 0) checkOutput($sformatf("rrNoBubble_%0d", i),
                             32'(((i % 2) == 1) ? rsp0_valid : rsp1_valid), 32'h1);
    end
    @(posedge g_clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge g_clk);
    checkOutput("rrLastRsp1", 32'(rsp1_valid), 32'h1);
    @(posedge g_clk); #1;

    // Port 0 32-bit rotate left.
    applyStimulus(0, 32'h8000_0001, 5'd1, 5'b00001, 1'b0, 1'b1, 1'b1, 1'b0);
    waitAccept(0);
    @(negedge g_clk);
    checkOutput("rotLValid", 32'(rsp0_valid), 32'h1);
    checkOutput("rotLResult", rsp0_result, 32'h0000_0003);
    checkOutput("rotLError", 32'(rsp0_error), 32'h0);
    checkOutput("rotLOther", 32'(rsp1_valid), 32'h0);
    @(posedge g_clk); #1;

    // Port 1 16-bit rotate right.
    applyStimulus(1, 32'h1234_5678, 5'd4, 5'b00010, 1'b0, 1'b1, 1'b0, 1'b1);
    waitAccept(1);
    @(negedge g_clk);
    checkOutput("rotRValid", 32'(rsp1_valid), 32'h1);
    checkOutput("rotRResult", rsp1_result, 32'h4123_8567);
    checkOutput("rotROther", 32'(rsp0_valid), 32'h0);
    @(posedge g_clk); #1;

    // Backpressure: port 0 holds its response, port 1 stalls until the drain.
    rsp0_ready = 1'b0;
    applyStimulus(0, 32'h80FF_7F01, 5'd1, 5'b00100, 1'b1, 1'b0, 1'b1, 1'b0);
    waitAccept(0);
    applyStimulus(1, 32'hCAFE_F00D, 5'd9, 5'b00001, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge g_clk);
      checkOutput($sformatf("stallValid_%0d", k), 32'(rsp0_valid), 32'h1);
      checkOutput($sformatf("stallResult_%0d", k), rsp0_result, 32'h00FE_FE02);
      checkOutput($sformatf("stallReady1_%0d", k), 32'(req1_ready), 32'h0);
    end
    @(posedge g_clk); #1;
    rsp0_ready = 1'b1;
    waitAccept(1);
    @(negedge g_clk);
    checkOutput("drainNoBubble", 32'(rsp1_valid), 32'h1);
    @(posedge g_clk); #1;

    // Malformed pack width.
    applyStimulus(0, 32'hDEAD_BEEF, 5'd3, 5'b00011, 1'b1, 1'b0, 1'b1, 1'b0);
    waitAccept(0);
    @(negedge g_clk);
`ifdef P_SHFROT_ARB_CHECK_EN
    checkOutput("badPwError", 32'(rsp0_error), 32'h1);
    checkOutput("badPwResult", rsp0_result, 32'h0);
`else
    checkOutput("badPwError", 32'(rsp0_error), 32'h0);
`endif
    @(posedge g_clk); #1;

    for (int r = 0; r < 12; r++) begin
      int p;
      logic op, dir;
      p   = int'($urandom_range(0, 1));
      op  = 1'($urandom_range(0, 1));
      dir = 1'($urandom_range(0, 1));
      applyStimulus(p, $urandom, 5'($urandom_range(0, 31)), 5'(1 << $urandom_range(0, 4)),
                    ~op, op, dir, ~dir);
      waitAccept(p);
    end
    @(posedge g_clk); #1;

    // Asynchronous reset while FULL, after port 0 was granted last.
    rsp0_ready = 1'b0;
    applyStimulus(0, 32'h0000_F00F, 5'd2, 5'b01000, 1'b0, 1'b1, 1'b1, 1'b0);
    waitAccept(0);
    @(negedge g_clk);
    checkOutput("preResetValid", 32'(rsp0_valid), 32'h1);
    applyStimulus(0, 32'h0F0F_0F0F, 5'd1, 5'b00001, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1, 32'hF0F0_F0F0, 5'd1, 5'b00001, 1'b1, 1'b0, 1'b0, 1'b1);
    #2;
    g_resetn = 1'b0;
    #1;
    checkOutput("asyncDropValid", 32'(rsp0_valid), 32'h0);
    checkOutput("asyncDropResult", rsp0_result, 32'h0);
    checkOutput("asyncReady0", 32'(req0_ready), 32'h0);
    checkOutput("asyncReady1", 32'(req1_ready), 32'h0);
    expQ0.delete();
    expQ1.delete();
    @(posedge g_clk); #1;
    g_resetn = 1'b1;
    rsp0_ready = 1'b1;
    @(negedge g_clk);
    checkOutput("postResetGrant0", 32'(req0_ready), 32'h1);
    checkOutput("postResetGrant1", 32'(req1_ready), 32'h0);
    @(posedge g_clk); #1;
    req0_valid = 1'b0;
    waitAccept(1);
    repeat (3) @(posedge g_clk);
    @(negedge g_clk);
    checkOutput("queue0Drained", 32'(expQ0.size()), 32'h0);
    checkOutput("queue1Drained", 32'(expQ1.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
